// File: rtl/nic_opl_pkg.sv
// Shared types and helpers for the NIC output port lookup: FSM encoding,
// default tuser field offsets, and the source-legality / destination-mapping functions.
package nic_opl_pkg;

    typedef enum logic [1:0] {S_HEAD, S_BODY, S_DROP} opl_state_t;

    localparam int SRC_LSB_DEF = 16;
    localparam int DST_LSB_DEF = 24;
    localparam int CNT_W       = 32;

    // Legal: exactly one bit set, and it lies inside the populated port range.
    function automatic logic src_legal(input logic [7:0] src, input int num_ports);
        logic [7:0] mask;
        for (int i = 0; i < 8; i++) mask[i] = (i < 2 * num_ports);
        return (src != 8'h00) && ((src & ~mask) == 8'h00) &&
               ((src & (src - 8'd1)) == 8'h00);
    endfunction

    // Swap each MAC/DMA pair; pairs flagged in refl are reflected back to the source.
    function automatic logic [7:0] dst_map(input logic [7:0] src, input logic [7:0] refl);
        logic [7:0] swp;
        for (int i = 0; i < 4; i++) begin
            swp[2*i]   = src[2*i+1];
            swp[2*i+1] = src[2*i];
        end
        return (src & refl) | (swp & ~refl);
    endfunction

endpackage

// File: rtl/nic_output_port_lookup_v2_skid.sv
// Two-entry AXI-Stream skid buffer with registered input ready and registered output.
// Entry q0 is always the head presented downstream; q1 catches the beat in flight when stalled.
module axis_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);
    logic [W-1:0] q0, q1;
    logic [1:0]   cnt, cnt_nxt;
    logic         push, pop;

    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_valid = (cnt != 2'd0);
    assign out_data  = q0;

    always_comb begin
        cnt_nxt = cnt;
        if (push && !pop)      cnt_nxt = cnt + 2'd1;
        else if (pop && !push) cnt_nxt = cnt - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q0       <= '0;
            q1       <= '0;
            cnt      <= 2'd0;
            in_ready <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            in_ready <= (cnt_nxt != 2'd2);
            // ready is low whenever cnt==2, so push never coincides with a full buffer
            if (pop && cnt == 2'd2)
                q0 <= q1;
            else if (push && (cnt == 2'd0 || pop))
                q0 <= in_data;
            if (push && !pop && cnt == 2'd1)
                q1 <= in_data;
        end
    end

endmodule

// File: rtl/nic_output_port_lookup_v2.sv
// NIC output port lookup: rewrites the tuser destination from the one-hot source,
// drops packets with an illegal source, and keeps saturating forward/drop counts.
// Optional macro NIC_OPL_LOOPBACK_EN adds a per-pair loopback input.
module nic_output_port_lookup_v2 import nic_opl_pkg::*; #(
    parameter int C_DATA_WIDTH  = 256,
    parameter int C_TUSER_WIDTH = 128,
    parameter int C_NUM_PORTS   = 4,
    parameter int C_SRC_LSB     = SRC_LSB_DEF,
    parameter int C_DST_LSB     = DST_LSB_DEF
) (
    input  logic                      axi_aclk,
    input  logic                      axi_reset,
    input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic [C_TUSER_WIDTH-1:0]  s_axis_tuser,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic [C_TUSER_WIDTH-1:0]  m_axis_tuser,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
`ifdef NIC_OPL_LOOPBACK_EN
    input  logic [C_NUM_PORTS-1:0]    loopback,
`endif
    input  logic                      clear_counters,
    output logic [CNT_W-1:0]          pkt_fwd_count,
    output logic [CNT_W-1:0]          pkt_drop_count
);
    localparam int STRB_W = C_DATA_WIDTH / 8;
    localparam int PW     = C_DATA_WIDTH + STRB_W + C_TUSER_WIDTH + 1;

    opl_state_t               state, state_nxt;
    logic                     skid_ready, accept, hdr_legal, fwd_valid, fwd_inc, drop_inc;
    logic [7:0]               src, dst, refl;
    logic [C_TUSER_WIDTH-1:0] user_fwd;
    logic [CNT_W-1:0]         fwd_cnt, drop_cnt;

    assign src       = s_axis_tuser[C_SRC_LSB +: 8];
    assign hdr_legal = src_legal(src, C_NUM_PORTS);

    always_comb begin
        refl = 8'h00;
`ifdef NIC_OPL_LOOPBACK_EN
        for (int i = 0; i < C_NUM_PORTS; i++) begin
            refl[2*i]   = loopback[i];
            refl[2*i+1] = loopback[i];
        end
`endif
    end

    assign dst = dst_map(src, refl);

    // Drop state sinks beats regardless of downstream backpressure.
    assign s_axis_tready = (state == S_DROP) || skid_ready;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign fwd_valid     = s_axis_tvalid &&
                           (state == S_BODY || (state == S_HEAD && hdr_legal));
    assign fwd_inc       = accept && (state == S_HEAD) && hdr_legal;
    assign drop_inc      = accept && (state == S_HEAD) && !hdr_legal;

    always_comb begin
        user_fwd = s_axis_tuser;
        if (state == S_HEAD) user_fwd[C_DST_LSB +: 8] = dst;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_HEAD:         if (accept && !s_axis_tlast) state_nxt = hdr_legal ? S_BODY : S_DROP;
            S_BODY, S_DROP: if (accept && s_axis_tlast)  state_nxt = S_HEAD;
            default:        state_nxt = S_HEAD;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) state <= S_HEAD;
        else           state <= state_nxt;
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset || clear_counters) begin
            fwd_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (fwd_inc && fwd_cnt != '1)   fwd_cnt  <= fwd_cnt + 1'b1;
            if (drop_inc && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign pkt_fwd_count  = fwd_cnt;
    assign pkt_drop_count = drop_cnt;

    logic [PW-1:0] skid_out;

    axis_skid_buffer #(.W(PW)) u_skid (
        .clk       (axi_aclk),
        .rst       (axi_reset),
        .in_data   ({s_axis_tdata, s_axis_tstrb, user_fwd, s_axis_tlast}),
        .in_valid  (fwd_valid),
        .in_ready  (skid_ready),
        .out_data  (skid_out),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready)
    );

    assign {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast} = skid_out;

endmodule

// File: tb/tb_nic_output_port_lookup_v2.sv
// Directed bench for nic_output_port_lookup_v2 (C_NUM_PORTS=3): header rewrite,
// backpressure/skid, drops, back-to-back streaming, counter saturation/clear, optional loopback.
module tb_nic_output_port_lookup_v2;
    localparam int DW = 256;
    localparam int UW = 128;
    localparam int NP = 3;

    logic            axi_aclk = 1'b0;
    logic            axi_reset = 1'b1;
    logic [DW-1:0]   s_axis_tdata = '0;
    logic [DW/8-1:0] s_axis_tstrb = '0;
    logic [UW-1:0]   s_axis_tuser = '0;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tready;
    logic            s_axis_tlast = 1'b0;
    logic [DW-1:0]   m_axis_tdata;
    logic [DW/8-1:0] m_axis_tstrb;
    logic [UW-1:0]   m_axis_tuser;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b1;
    logic            m_axis_tlast;
    logic            clear_counters = 1'b0;
    logic [31:0]     pkt_fwd_count, pkt_drop_count;
`ifdef NIC_OPL_LOOPBACK_EN
    logic [NP-1:0]   loopback = '0;
`endif

    always #5 axi_aclk = ~axi_aclk;

    nic_output_port_lookup_v2 #(
        .C_DATA_WIDTH(DW), .C_TUSER_WIDTH(UW), .C_NUM_PORTS(NP),
        .C_SRC_LSB(16), .C_DST_LSB(24)
    ) dut (
        .axi_aclk(axi_aclk), .axi_reset(axi_reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
`ifdef NIC_OPL_LOOPBACK_EN
        .loopback(loopback),
`endif
        .clear_counters(clear_counters),
        .pkt_fwd_count(pkt_fwd_count), .pkt_drop_count(pkt_drop_count)
    );

    int n_chk = 0;
    int n_err = 0;
    int stall_cyc = 0;
    logic vld_seen = 1'b0;
    logic [31:0] cyc = '0;

    typedef struct packed {
        logic [31:0]   c;
        logic [31:0]   d;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;
    beat_t mq[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [UW-1:0] mk_user(input logic [7:0] src, input logic [7:0] dst,
                                              input logic [31:0] tag);
        return {64'h0123_4567_89AB_CDEF, tag, dst, src, 16'hBEEF};
    endfunction

    // Beats handshake at the following posedge, since inputs only change at posedge+1.
    always @(negedge axi_aclk) begin
        cyc = cyc + 32'd1;
        if (m_axis_tvalid) vld_seen = 1'b1;
        if (!axi_reset && m_axis_tvalid && m_axis_tready)
            mq.push_back('{c: cyc, d: m_axis_tdata[31:0], u: m_axis_tuser, l: m_axis_tlast});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge axi_aclk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic [UW-1:0] u, input logic l);
        s_axis_tdata  = DW'(d);
        s_axis_tstrb  = '1;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
    endtask

    task automatic wait_acc();
        int n = 0;
        @(negedge axi_aclk);
        while (!s_axis_tready && n < 50) begin
            n++;
            stall_cyc++;
            @(negedge axi_aclk);
        end
        if (!s_axis_tready) chk("accept_timeout", 0, 1);
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [UW-1:0] u, input logic l);
        drive(d, u, l);
        wait_acc();
    endtask

    task automatic idle();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, nl;
        logic [7:0] srcs [2];
        srcs[0] = 8'h02;
        srcs[1] = 8'h10;

        repeat (3) @(negedge axi_aclk);
        chk("rst_s_ready", s_axis_tready, 0);
        chk("rst_m_valid", m_axis_tvalid, 0);
        chk("rst_m_user", m_axis_tuser, 0);
        chk("rst_m_data", m_axis_tdata[127:0], 0);
        chk("rst_fwd", pkt_fwd_count, 0);
        chk("rst_drop", pkt_drop_count, 0);
        @(posedge axi_aclk); #1 axi_reset = 1'b0;
        @(posedge axi_aclk); @(negedge axi_aclk);
        chk("ready_after_rst", s_axis_tready, 1);
        tick(1);

        // single-beat MAC0 packet
        mq.delete();
        send(32'h1111, mk_user(8'h01, 8'hAA, 32'd1), 1'b1);
        idle();
        @(negedge axi_aclk);
        chk("t1_valid", m_axis_tvalid, 1);
        chk("t1_user", m_axis_tuser, mk_user(8'h01, 8'h02, 32'd1));
        chk("t1_last", m_axis_tlast, 1);
        chk("t1_data", m_axis_tdata[31:0], 32'h1111);
        chk("t1_fwd", pkt_fwd_count, 1);
        @(negedge axi_aclk);
        chk("t1_gone", m_axis_tvalid, 0);
        tick(1);

        // 3-beat DMA1 packet with downstream stall
        m_axis_tready = 1'b0;
        mq.delete();
        send(32'h2000, mk_user(8'h08, 8'h55, 32'd2), 1'b0);
        send(32'h2001, mk_user(8'h08, 8'h55, 32'd2), 1'b0);
        drive(32'h2002, mk_user(8'h08, 8'h55, 32'd2), 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge axi_aclk);
            chk("t2_stall_ready", s_axis_tready, 0);
            chk("t2_hold_user", m_axis_tuser, mk_user(8'h08, 8'h04, 32'd2));
            chk("t2_hold_data", m_axis_tdata[31:0], 32'h2000);
        end
        @(posedge axi_aclk); #1 m_axis_tready = 1'b1;
        wait_acc();
        idle();
        tick(5);
        chk("t2_beats", mq.size(), 3);
        chk("t2_order", {mq[0].d, mq[1].d, mq[2].d}, {32'h2000, 32'h2001, 32'h2002});
        chk("t2_hdr", mq[0].u, mk_user(8'h08, 8'h04, 32'd2));
        chk("t2_body", mq[1].u, mk_user(8'h08, 8'h55, 32'd2));
        chk("t2_lasts", {mq[0].l, mq[1].l, mq[2].l}, 3'b001);
        chk("t2_fwd", pkt_fwd_count, 2);

        // illegal sources: none, two bits, out-of-range port
        mq.delete();
        vld_seen = 1'b0;
        send(32'h3000, mk_user(8'h00, 8'h00, 32'd3), 1'b1);
        send(32'h3100, mk_user(8'h03, 8'h00, 32'd3), 1'b0);
        send(32'h3101, mk_user(8'h03, 8'h00, 32'd3), 1'b1);
        send(32'h3200, mk_user(8'h40, 8'h00, 32'd3), 1'b1);
        idle();
        tick(3);
        chk("t3_no_valid", vld_seen, 0);
        chk("t3_drop", pkt_drop_count, 3);
        chk("t3_fwd", pkt_fwd_count, 2);

        // two back-to-back 64-beat packets
        mq.delete();
        stall_cyc = 0;
        for (int p = 0; p < 2; p++)
            for (int b = 0; b < 64; b++)
                send(32'(p * 64 + b),
                     (b == 0) ? mk_user(srcs[p], 8'h00, 32'(4 + p)) : mk_user(8'hFF, 8'hEE, 32'(b)),
                     b == 63);
        idle();
        tick(5);
        chk("t4_stalls", stall_cyc, 0);
        chk("t4_beats", mq.size(), 128);
        bad = 0;
        nl = 0;
        foreach (mq[i]) begin
            if (mq[i].d != 32'(i)) bad++;
            if (mq[i].l) nl++;
        end
        chk("t4_order", bad, 0);
        chk("t4_lasts", nl, 2);
        chk("t4_hdr0", mq[0].u, mk_user(8'h02, 8'h01, 32'd4));
        chk("t4_hdr1", mq[64].u, mk_user(8'h10, 8'h20, 32'd5));
        chk("t4_body", mq[1].u, mk_user(8'hFF, 8'hEE, 32'd1));
        chk("t4_span", mq[127].c - mq[0].c, 127);
        chk("t4_fwd", pkt_fwd_count, 4);

        // counter clear, saturation, clear-vs-increment priority
        clear_counters = 1'b1;
        tick(1);
        clear_counters = 1'b0;
        chk("t5_clr_fwd", pkt_fwd_count, 0);
        chk("t5_clr_drop", pkt_drop_count, 0);
        force dut.fwd_cnt = 32'hFFFF_FFFF;
        tick(1);
        release dut.fwd_cnt;
        send(32'h5000, mk_user(8'h01, 8'h00, 32'd6), 1'b1);
        idle();
        tick(2);
        chk("t5_sat", pkt_fwd_count, 32'hFFFF_FFFF);
        clear_counters = 1'b1;
        send(32'h5100, mk_user(8'h01, 8'h00, 32'd7), 1'b1);
        clear_counters = 1'b0;
        idle();
        tick(2);
        chk("t5_clr_prio", pkt_fwd_count, 0);

`ifdef NIC_OPL_LOOPBACK_EN
        loopback = 3'b010;
        mq.delete();
        send(32'h6000, mk_user(8'h04, 8'h00, 32'd8), 1'b1);
        send(32'h6001, mk_user(8'h01, 8'h00, 32'd9), 1'b1);
        idle();
        tick(3);
        chk("t6_beats", mq.size(), 2);
        chk("t6_refl", mq[0].u, mk_user(8'h04, 8'h04, 32'd8));
        chk("t6_pair", mq[1].u, mk_user(8'h01, 8'h02, 32'd9));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
